phase_lock_controller: RTL and testbench

- Single-clock sequencer that consumes the phase / phase_valid stream of the four-phase sampling block, in the clk_0 domain.
- Acquires a histogram of NUM_SAMPLES phase reports and picks the majority phase. Declares lock if that phase meets THRESHOLD.
- Once locked, tracks the stream and automatically re-acquires after MISMATCH_LIMIT consecutive disagreeing reports.
- Drives downstream data-recovery phase selection and reports status to software.

---
 rtl/phase_lock_pkg.sv | 21 ++
 rtl/phase_lock_controller_histogram.sv | 43 ++++
 rtl/phase_lock_controller.sv | 186 ++++++++++++++++++
 tb/tb_phase_lock_controller.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_lock_pkg.sv
// Shared types and status codes for the phase lock controller.
package phase_lock_pkg;

  localparam int unsigned NUM_PHASES = 4;

  typedef logic [1:0] phase_t;
  typedef logic [1:0] status_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACQUIRE = 3'd1,
    ST_DECIDE  = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_FAIL    = 3'd4
  } plc_state_t;

  localparam status_t PLC_OK        = 2'b00;
  localparam status_t PLC_TIMEOUT   = 2'b01;
  localparam status_t PLC_AMBIGUOUS = 2'b10;

endpackage

// File: rtl/phase_lock_controller_histogram.sv
// Four saturating phase bins with a combinational majority picker.
module phase_histogram
  import phase_lock_pkg::*;
#(
  parameter int unsigned CW      = 5,
  parameter int unsigned BIN_MAX = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          inc_i,
  input  phase_t        phase_i,
  output phase_t        winner_c,
  output logic [CW-1:0] winner_count_c
);

  localparam logic [CW-1:0] BIN_SAT = CW'(BIN_MAX);

  logic [CW-1:0] bin_q [NUM_PHASES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PHASES; i++) bin_q[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < NUM_PHASES; i++) bin_q[i] <= '0;
    end else if (inc_i && (bin_q[phase_i] != BIN_SAT)) begin
      bin_q[phase_i] <= bin_q[phase_i] + 1'b1;
    end
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    winner_c       = '0;
    winner_count_c = bin_q[0];
    for (int i = 1; i < NUM_PHASES; i++) begin
      if (bin_q[i] > winner_count_c) begin
        winner_c       = 2'(i);
        winner_count_c = bin_q[i];
      end
    end
  end

endmodule

// File: rtl/phase_lock_controller.sv
// Acquires a phase histogram, locks onto the majority phase and tracks it,
// re-acquiring after a run of disagreeing reports.
module phase_lock_controller
  import phase_lock_pkg::*;
#(
  parameter int unsigned NUM_SAMPLES    = 16,
  parameter int unsigned THRESHOLD      = 12,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MISMATCH_LIMIT = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    start,
  input  logic    abort,
  input  phase_t  phase,
  input  logic    phase_valid,
  output logic    busy,
  output logic    locked,
  output phase_t  lock_phase,
  output logic    done,
  output logic    lost_lock,
  output status_t status
);

  localparam int unsigned CW = $clog2(NUM_SAMPLES + 1);
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned MW = $clog2(MISMATCH_LIMIT + 1);

  localparam logic [CW-1:0] SAMPLES_LAST = CW'(NUM_SAMPLES - 1);
  localparam logic [CW-1:0] THRESH       = CW'(THRESHOLD);
  localparam logic [TW-1:0] TMO_LAST     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [MW-1:0] MM_LAST      = MW'(MISMATCH_LIMIT - 1);

  plc_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [MW-1:0] mm_q, mm_d;
  logic          busy_q, busy_d;
  logic          locked_q, locked_d;
  phase_t        lock_phase_q, lock_phase_d;
  logic          done_q, done_d;
  logic          lost_q, lost_d;
  status_t       status_q, status_d;

  logic          hist_clear;
  logic          hist_inc;
  logic          acq_entry;
  phase_t        winner;
  logic [CW-1:0] winner_count;

  phase_histogram #(
    .CW      (CW),
    .BIN_MAX (NUM_SAMPLES)
  ) u_hist (
    .clk            (clk),
    .rst_n          (rst),
    .clear_i        (hist_clear),
    .inc_i          (hist_inc),
    .phase_i        (phase),
    .winner_c       (winner),
    .winner_count_c (winner_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      tmo_q        <= '0;
      mm_q         <= '0;
      busy_q       <= 1'b0;
      locked_q     <= 1'b0;
      lock_phase_q <= '0;
      done_q       <= 1'b0;
      lost_q       <= 1'b0;
      status_q     <= PLC_OK;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      mm_q         <= mm_d;
      busy_q       <= busy_d;
      locked_q     <= locked_d;
      lock_phase_q <= lock_phase_d;
      done_q       <= done_d;
      lost_q       <= lost_d;
      status_q     <= status_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    mm_d         = mm_q;
    lock_phase_d = lock_phase_q;
    status_d     = status_q;
    done_d       = 1'b0;
    lost_d       = 1'b0;
    hist_clear   = 1'b0;
    hist_inc     = 1'b0;
    acq_entry    = 1'b0;

    if (abort) begin
      state_d    = ST_IDLE;
      status_d   = PLC_OK;
      hist_clear = 1'b1;
      cnt_d      = '0;
      tmo_d      = '0;
      mm_d       = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) acq_entry = 1'b1;
        end
        ST_ACQUIRE: begin
          // The final sample outranks a timeout landing in the same cycle.
          if (phase_valid) begin
            hist_inc = 1'b1;
            cnt_d    = cnt_q + 1'b1;
          end
          if (phase_valid && (cnt_q == SAMPLES_LAST)) begin
            state_d = ST_DECIDE;
          end else if (tmo_q == TMO_LAST) begin
            state_d  = ST_FAIL;
            status_d = PLC_TIMEOUT;
            done_d   = 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        ST_DECIDE: begin
          done_d = 1'b1;
          if (winner_count >= THRESH) begin
            state_d      = ST_LOCKED;
            lock_phase_d = winner;
            status_d     = PLC_OK;
            mm_d         = '0;
          end else begin
            state_d  = ST_FAIL;
            status_d = PLC_AMBIGUOUS;
          end
        end
        ST_LOCKED: begin
          if (start) begin
            acq_entry = 1'b1;
          end else if (phase_valid) begin
            if (phase == lock_phase_q) begin
              mm_d = '0;
            end else if (mm_q == MM_LAST) begin
              acq_entry = 1'b1;
              lost_d    = 1'b1;
            end else begin
              mm_d = mm_q + 1'b1;
            end
          end
        end
        ST_FAIL: begin
          if (start) acq_entry = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (acq_entry) begin
      state_d    = ST_ACQUIRE;
      hist_clear = 1'b1;
      cnt_d      = '0;
      tmo_d      = '0;
      mm_d       = '0;
      status_d   = PLC_OK;
    end

    busy_d   = (state_d == ST_ACQUIRE) || (state_d == ST_DECIDE);
    locked_d = (state_d == ST_LOCKED);
  end

  assign busy       = busy_q;
  assign locked     = locked_q;
  assign lock_phase = lock_phase_q;
  assign done       = done_q;
  assign lost_lock  = lost_q;
  assign status     = status_q;

endmodule

// File: tb/tb_phase_lock_controller.sv
// Directed and random stimulus on two controllers (THRESHOLD 12 and 8)
// against a cycle-level behavioural model.
module tb_phase_lock_controller;

  localparam int N_SAMP  = 16;
  localparam int TMO     = 1024;
  localparam int MM_LIM  = 4;
  localparam int THR [2] = '{12, 8};

  localparam int M_IDLE   = 0;
  localparam int M_ACQ    = 1;
  localparam int M_DECIDE = 2;
  localparam int M_LOCKED = 3;
  localparam int M_FAILED = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [1:0] phase;
  logic       phase_valid;

  logic       busy0, locked0, done0, lost0;
  logic [1:0] lp0, st0;
  logic       busy1, locked1, done1, lost1;
  logic [1:0] lp1, st1;

  int errors = 0;
  int checks = 0;

  int m_mode [2];
  int m_bins [2][4];
  int m_samples [2];
  int m_acq [2];
  int m_mism [2];
  int e_busy [2];
  int e_locked [2];
  int e_lp [2];
  int e_done [2];
  int e_lost [2];
  int e_status [2];

  always #5 clk = ~clk;

  phase_lock_controller #(
    .NUM_SAMPLES(16), .THRESHOLD(12), .TIMEOUT_CYCLES(1024), .MISMATCH_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .phase(phase),
    .phase_valid(phase_valid), .busy(busy0), .locked(locked0),
    .lock_phase(lp0), .done(done0), .lost_lock(lost0), .status(st0)
  );

  phase_lock_controller #(
    .NUM_SAMPLES(16), .THRESHOLD(8), .TIMEOUT_CYCLES(1024), .MISMATCH_LIMIT(4)
  ) dut_t8 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .phase(phase),
    .phase_valid(phase_valid), .busy(busy1), .locked(locked1),
    .lock_phase(lp1), .done(done1), .lost_lock(lost1), .status(st1)
  );

  task automatic check(input string tag, input logic [1:0] obs, input int exp);
    checks++;
    assert (obs === 2'(exp)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_IDLE;
      for (int b = 0; b < 4; b++) m_bins[k][b] = 0;
      m_samples[k] = 0; m_acq[k] = 0; m_mism[k] = 0;
      e_busy[k] = 0; e_locked[k] = 0; e_lp[k] = 0;
      e_done[k] = 0; e_lost[k] = 0; e_status[k] = 0;
    end
  endtask

  task automatic begin_acquire(input int k);
    m_mode[k] = M_ACQ;
    for (int b = 0; b < 4; b++) m_bins[k][b] = 0;
    m_samples[k] = 0; m_acq[k] = 0; m_mism[k] = 0;
    e_status[k] = 0;
  endtask

  task automatic model_step(input int k, input bit s, input bit a, input int p, input bit v);
    int best;
    e_done[k] = 0;
    e_lost[k] = 0;
    if (a) begin
      m_mode[k] = M_IDLE;
      e_status[k] = 0;
      for (int b = 0; b < 4; b++) m_bins[k][b] = 0;
    end else begin
      case (m_mode[k])
        M_IDLE:   if (s) begin_acquire(k);
        M_ACQ: begin
          m_acq[k]++;
          if (v) begin
            m_bins[k][p]++;
            m_samples[k]++;
          end
          if (v && m_samples[k] == N_SAMP) m_mode[k] = M_DECIDE;
          else if (m_acq[k] == TMO) begin
            m_mode[k] = M_FAILED; e_status[k] = 1; e_done[k] = 1;
          end
        end
        M_DECIDE: begin
          best = 0;
          for (int b = 1; b < 4; b++) if (m_bins[k][b] > m_bins[k][best]) best = b;
          e_done[k] = 1;
          if (m_bins[k][best] >= THR[k]) begin
            m_mode[k] = M_LOCKED; e_lp[k] = best; e_status[k] = 0; m_mism[k] = 0;
          end else begin
            m_mode[k] = M_FAILED; e_status[k] = 2;
          end
        end
        M_LOCKED: begin
          if (s) begin_acquire(k);
          else if (v) begin
            if (p == e_lp[k]) m_mism[k] = 0;
            else begin
              m_mism[k]++;
              if (m_mism[k] == MM_LIM) begin
                begin_acquire(k);
                e_lost[k] = 1;
              end
            end
          end
        end
        default:  if (s) begin_acquire(k);
      endcase
    end
    e_busy[k]   = (m_mode[k] == M_ACQ || m_mode[k] == M_DECIDE) ? 1 : 0;
    e_locked[k] = (m_mode[k] == M_LOCKED) ? 1 : 0;
  endtask

  task automatic check_all();
    check("t12_busy",   {1'b0, busy0},   e_busy[0]);
    check("t12_locked", {1'b0, locked0}, e_locked[0]);
    check("t12_phase",  lp0,             e_lp[0]);
    check("t12_done",   {1'b0, done0},   e_done[0]);
    check("t12_lost",   {1'b0, lost0},   e_lost[0]);
    check("t12_status", st0,             e_status[0]);
    check("t8_busy",    {1'b0, busy1},   e_busy[1]);
    check("t8_locked",  {1'b0, locked1}, e_locked[1]);
    check("t8_phase",   lp1,             e_lp[1]);
    check("t8_done",    {1'b0, done1},   e_done[1]);
    check("t8_lost",    {1'b0, lost1},   e_lost[1]);
    check("t8_status",  st1,             e_status[1]);
  endtask

  task automatic tick(input bit s, input bit a, input int p, input bit v);
    start = s; abort = a; phase = 2'(p); phase_valid = v;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, s, a, p, v);
    #1;
    check_all();
    start = 1'b0; abort = 1'b0; phase_valid = 1'b0;
  endtask

  initial begin
    int dom;
    rst = 1'b0; start = 1'b0; abort = 1'b0; phase = 2'd0; phase_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;

    // Reset in the middle of an acquisition, then a clean lock on phase 2.
    tick(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, $urandom_range(0, 3), 1);
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;

    tick(1, 0, 0, 0);
    for (int i = 0; i < N_SAMP; i++) tick(0, 0, 2, 1);
    check("lock_busy_decide", {1'b0, busy0}, 1);
    tick(0, 0, 0, 0);
    check("lock_done", {1'b0, done0}, 1);
    check("lock_locked", {1'b0, locked0}, 1);
    check("lock_phase", lp0, 2);
    check("lock_status", st0, 0);
    tick(0, 0, 0, 0);
    check("lock_done_once", {1'b0, done0}, 0);

    // Mismatch run broken by one agreeing report, then four in a row.
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 1);
    tick(0, 0, 2, 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 1);
    check("loss_not_yet", {1'b0, locked0}, 1);
    tick(0, 0, 1, 1);
    check("loss_pulse", {1'b0, lost0}, 1);
    check("loss_busy", {1'b0, busy0}, 1);
    check("loss_locked", {1'b0, locked0}, 0);
    check("loss_phase_held", lp0, 2);

    // Even split: ambiguous at 12, locks to lower index at 8.
    for (int i = 0; i < 8; i++) tick(0, 0, 1, 1);
    for (int i = 0; i < 8; i++) tick(0, 0, 3, 1);
    tick(0, 0, 0, 0);
    check("ambig_status", st0, 2);
    check("ambig_done", {1'b0, done0}, 1);
    check("ambig_phase_held", lp0, 2);
    check("t8_split_phase", lp1, 1);

    tick(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) tick(0, 0, 3, 1);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
    check("relock_phase", lp0, 3);
    check("relock_locked", {1'b0, locked0}, 1);

    // Abort beats start.
    tick(1, 1, 0, 1);
    check("abort_locked", {1'b0, locked0}, 0);
    check("abort_busy", {1'b0, busy0}, 0);
    check("abort_done", {1'b0, done0}, 0);
    check("abort_phase_held", lp0, 3);

    tick(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) tick(0, 0, 2, 1);
    for (int i = 0; i < 8; i++) tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
    check("tie_phase", lp1, 0);
    check("tie_status_t12", st0, 2);

    // Timeout with only 15 reports.
    tick(1, 0, 0, 0);
    for (int k = 1; k <= TMO; k++) begin
      tick(0, 0, $urandom_range(0, 3), k <= 15);
      if (k == TMO - 1) check("tmo_not_yet", st0, 0);
    end
    check("tmo_status", st0, 1);
    check("tmo_done", {1'b0, done0}, 1);
    check("tmo_busy", {1'b0, busy0}, 0);
    repeat (3) tick(0, 0, 1, 1);

    // Sixteenth report on the final timeout cycle wins.
    tick(1, 0, 0, 0);
    for (int k = 1; k <= TMO; k++) tick(0, 0, 2, (k <= 15) || (k == TMO));
    check("edge_decide_busy", {1'b0, busy0}, 1);
    check("edge_status", st0, 0);
    tick(0, 0, 0, 0);
    check("edge_locked", {1'b0, locked0}, 1);
    check("edge_done", {1'b0, done0}, 1);

    // Random soak with a drifting dominant phase.
    dom = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) dom = $urandom_range(0, 3);
      tick($urandom_range(0, 63) == 0, $urandom_range(0, 255) == 0,
           ($urandom_range(0, 3) != 0) ? dom : $urandom_range(0, 3),
           $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
